// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- iterative radix-2 restoring divider for the RV32M divide group
//             (DIV, DIVU, REM, REMU).
//
// Sits beside the execute-stage ALU, sharing the operand buses and the 5-bit
// alu_op encoding. A launch takes 33 cycles from start to done on the normal
// path: 32 CALC cycles, then a single-cycle DONE state. Divide-by-zero and
// signed overflow complete in one cycle (fast path) without ever raising busy.
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   When defined, any operation whose dividend magnitude is strictly below a
//   non-zero divisor magnitude also takes the fast path. The quotient is 0 and
//   the remainder is the dividend. Results are identical either way; only the
//   latency changes.
//
// Ports:
//   clk     in   1     clock, rising edge
//   rst     in   1     synchronous active-high reset
//   start   in   1     launch request, honoured in IDLE or DONE only
//   flush   in   1     synchronous abort, has priority over start
//   a       in   XLEN  dividend (rs1)
//   b       in   XLEN  divisor (rs2)
//   alu_op  in   5     10111 DIV, 11000 DIVU, 11001 REM, 11010 REMU
//   busy    out  1     high while iterating (CALC)
//   done    out  1     one-cycle completion pulse, result valid
//   result  out  XLEN  quotient/remainder, held until the next completion
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      alu_op,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [4:0] OP_DIV  = 5'b10111;
    localparam logic [4:0] OP_DIVU = 5'b11000;
    localparam logic [4:0] OP_REM  = 5'b11001;
    localparam logic [4:0] OP_REMU = 5'b11010;

    localparam logic [5:0] LAST_ITER = 6'd31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state_reg;
    logic            busy_reg;
    logic            done_reg;
    logic [XLEN-1:0] result_reg;
    logic [5:0]      count_reg;
    logic [XLEN-1:0] quo_reg;      // dividend bits shift out, quotient bits shift in
    logic [XLEN-1:0] rem_reg;      // partial remainder, always < divisor
    logic [XLEN-1:0] divisor_reg;  // divisor magnitude
    logic            neg_q_reg;
    logic            neg_r_reg;
    logic            is_rem_reg;

    // ------------------------------------------------------------------
    // Launch decode on the live input buses
    // ------------------------------------------------------------------
    logic            op_valid;
    logic            op_signed;
    logic            op_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            b_zero;
    logic            ovf;
    logic            early_out;
    logic            fast_hit;
    logic [XLEN-1:0] fast_value;
    logic            launch;

    assign op_valid  = (alu_op == OP_DIV) || (alu_op == OP_DIVU) ||
                       (alu_op == OP_REM) || (alu_op == OP_REMU);
    assign op_signed = (alu_op == OP_DIV) || (alu_op == OP_REM);
    assign op_rem    = (alu_op == OP_REM) || (alu_op == OP_REMU);

    assign a_neg = op_signed && a[XLEN-1];
    assign b_neg = op_signed && b[XLEN-1];
    // The most negative value negates to itself, which is still the correct
    // unsigned magnitude.
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign b_zero = (b == '0);
    assign ovf    = op_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

`ifdef DIV_EARLY_OUT_EN
    assign early_out = !b_zero && (a_mag < b_mag);
`else
    assign early_out = 1'b0;
`endif

    assign fast_hit = b_zero || ovf || early_out;
    assign launch   = start && op_valid;

    always_comb begin
        fast_value = '0;
        if (b_zero) begin
            fast_value = op_rem ? a : '1;
        end else if (ovf) begin
            // Quotient of the overflow case equals the dividend itself.
            fast_value = op_rem ? '0 : a;
        end else begin
            // Early-out: |a| < |b| so quotient 0, remainder is the dividend.
            fast_value = op_rem ? a : '0;
        end
    end

    // ------------------------------------------------------------------
    // One restoring shift-subtract step on a 33-bit partial remainder
    // ------------------------------------------------------------------
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] result_next;

    assign shifted = {rem_reg, quo_reg[XLEN-1]};
    assign trial   = shifted - {1'b0, divisor_reg};

    always_comb begin
        quo_next = {quo_reg[XLEN-2:0], 1'b0};
        rem_next = shifted[XLEN-1:0];
        // No borrow out of the top bit means the divisor fits: keep the
        // difference and set the quotient bit.
        if (!trial[XLEN]) begin
            quo_next = {quo_reg[XLEN-2:0], 1'b1};
            rem_next = trial[XLEN-1:0];
        end
    end

    // Sign fix-up applied to the values produced by the final iteration.
    always_comb begin
        result_next = '0;
        if (is_rem_reg) begin
            result_next = neg_r_reg ? -rem_next : rem_next;
        end else begin
            result_next = neg_q_reg ? -quo_next : quo_next;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            result_reg  <= '0;
            count_reg   <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            is_rem_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (flush) begin
                state_reg <= S_IDLE;
                busy_reg  <= 1'b0;
                count_reg <= '0;
            end else begin
                case (state_reg)
                    S_IDLE, S_DONE: begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                        if (launch) begin
                            if (fast_hit) begin
                                result_reg <= fast_value;
                                done_reg   <= 1'b1;
                                state_reg  <= S_DONE;
                            end else begin
                                quo_reg     <= a_mag;
                                rem_reg     <= '0;
                                divisor_reg <= b_mag;
                                neg_q_reg   <= a_neg ^ b_neg;
                                neg_r_reg   <= a_neg;
                                is_rem_reg  <= op_rem;
                                count_reg   <= '0;
                                busy_reg    <= 1'b1;
                                state_reg   <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        quo_reg <= quo_next;
                        rem_reg <= rem_next;
                        if (count_reg == LAST_ITER) begin
                            result_reg <= result_next;
                            done_reg   <= 1'b1;
                            busy_reg   <= 1'b0;
                            count_reg  <= '0;
                            state_reg  <= S_DONE;
                        end else begin
                            count_reg <= count_reg + 6'd1;
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- scoreboard bench for div_unit.
// The stimulus process pushes the expected result, completion cycle and busy
// length for each launch, plus point-in-time probes (busy/result at a given
// cycle). A monitor on the falling edge pops and compares whenever done is
// seen, flags any unexpected or missing done, and prints the summary.
// -----------------------------------------------------------------------------
module tb_div_unit;

    localparam logic [4:0] OP_DIV  = 5'b10111;
    localparam logic [4:0] OP_DIVU = 5'b11000;
    localparam logic [4:0] OP_REM  = 5'b11001;
    localparam logic [4:0] OP_REMU = 5'b11010;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT  = 1;
    localparam int EO_BUSY = 0;
`else
    localparam int EO_LAT  = 33;
    localparam int EO_BUSY = 32;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  alu_op;
    logic        busy;
    logic        done;
    logic [31:0] result;

    div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .a      (a),
        .b      (b),
        .alu_op (alu_op),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] value;
        int          cycle;
        int          busy_n;
        int          tag;
    } exp_t;

    typedef struct {
        int          cycle;
        logic        busy_v;
        logic [31:0] value;
        int          tag;
    } probe_t;

    exp_t   exp_q[$];
    probe_t pq[$];

    int   checks = 0;
    int   failures = 0;
    int   busy_run = 0;
    logic finish_req = 1'b0;

    logic [31:0] last_exp = 32'h0;
    int          tag_n = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one cycle; afterwards scramble the operand buses so a
    // design that fails to capture them at launch is caught.
    task automatic launch_raw(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv);
        start  = 1'b1;
        alu_op = op;
        a      = av;
        b      = bv;
        tick();
        start  = 1'b0;
        a      = $urandom;
        b      = $urandom;
        alu_op = OP_DIV;
    endtask

    task automatic launch(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] ev, input int lat, input int busy_n);
        exp_t e;
        e.value  = ev;
        e.cycle  = cyc + lat;
        e.busy_n = busy_n;
        e.tag    = tag_n;
        tag_n++;
        exp_q.push_back(e);
        last_exp = ev;
        $display("launch op%0d alu_op=%b a=%08h b=%08h expect=%08h in %0d cycles",
                 e.tag, op, av, bv, ev, lat);
        launch_raw(op, av, bv);
    endtask

    task automatic run(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ev, input int lat, input int busy_n);
        launch(op, av, bv, ev, lat, busy_n);
        repeat (lat + 1) tick();
    endtask

    task automatic probe(input int at, input logic bv, input logic [31:0] rv);
        probe_t p;
        p.cycle  = at;
        p.busy_v = bv;
        p.value  = rv;
        p.tag    = tag_n;
        tag_n++;
        pq.push_back(p);
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t   e;
        probe_t p;
        if (done) begin
            checks++;
            if (busy) begin
                failures++;
                $display("FAIL busy_with_done cycle=%0d busy=%b required=0", cyc, busy);
            end
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done cycle=%0d result=%08h required=no done", cyc, result);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (result !== e.value) begin
                    failures++;
                    $display("FAIL result op%0d got=%08h required=%08h", e.tag, result, e.value);
                end
                checks++;
                if (cyc != e.cycle) begin
                    failures++;
                    $display("FAIL done_cycle op%0d got=%0d required=%0d", e.tag, cyc, e.cycle);
                end
                checks++;
                if (busy_run != e.busy_n) begin
                    failures++;
                    $display("FAIL busy_cycles op%0d got=%0d required=%0d", e.tag, busy_run, e.busy_n);
                end
                $display("done op%0d cycle=%0d result=%08h busy_cycles=%0d", e.tag, cyc, result, busy_run);
            end
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
        end else begin
            busy_run = 0;
        end

        if (exp_q.size() > 0 && cyc > exp_q[0].cycle) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_done op%0d got=no done by cycle %0d required=done at %0d",
                     e.tag, cyc, e.cycle);
        end

        while (pq.size() > 0 && pq[0].cycle <= cyc) begin
            p = pq.pop_front();
            checks++;
            if (busy !== p.busy_v) begin
                failures++;
                $display("FAIL probe_busy p%0d cycle=%0d got=%b required=%b", p.tag, cyc, busy, p.busy_v);
            end
            checks++;
            if (result !== p.value) begin
                failures++;
                $display("FAIL probe_result p%0d cycle=%0d got=%08h required=%08h", p.tag, cyc, result, p.value);
            end
            $display("probe p%0d cycle=%0d busy=%b done=%b result=%08h", p.tag, cyc, busy, done, result);
        end

        if (finish_req) begin
            checks++;
            if (exp_q.size() != 0 || pq.size() != 0) begin
                failures++;
                $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size() + pq.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int c0;
        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        a      = 32'h0;
        b      = 32'h0;
        alu_op = 5'b00000;
        repeat (3) tick();
        rst = 1'b0;
        probe(cyc, 1'b0, 32'h0);   // reset state
        tick();

        // Non-divide opcodes (ADD, MULU, one past REMU) must be ignored.
        launch_raw(5'b00000, 32'd10, 32'd2);
        probe(cyc, 1'b0, 32'h0);
        launch_raw(5'b10110, 32'd10, 32'd2);
        launch_raw(5'b11011, 32'd10, 32'd2);
        probe(cyc, 1'b0, 32'h0);
        repeat (36) tick();

        // Normal path, unsigned.
        run(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 32);

        // Signed, then REM launched back-to-back in the DONE cycle.
        launch(OP_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33, 32);
        repeat (32) tick();
        run(OP_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33, 32);

        // Negative divisor, and unsigned with all-ones dividend.
        run(OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 32);
        run(OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33, 32);
        run(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33, 32);
        run(OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 33, 32);
        // Most negative dividend over 1 is a normal (non-overflow) case.
        run(OP_DIV,  32'h8000_0000, 32'd1, 32'h8000_0000, 33, 32);

        // Divide by zero, back-to-back fast paths.
        launch(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run(OP_REMU, 32'd5, 32'd0, 32'd5, 1, 0);

        // Signed overflow, back-to-back fast paths.
        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);

        // |a| < |b| cases; latency depends on the early-out build option.
        run(OP_REMU, 32'd3, 32'd10, 32'd3, EO_LAT, EO_BUSY);
        run(OP_DIV,  32'hFFFF_FFFD, 32'd10, 32'h0, EO_LAT, EO_BUSY);
        run(OP_REM,  32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, EO_LAT, EO_BUSY);

        // Flush at cycle 10 with an ignored start pulse at cycle 5.
        c0 = cyc;
        launch_raw(OP_DIVU, 32'd1000, 32'd3);      // cycle c0, no done expected
        repeat (4) tick();                         // cycle c0+5
        start  = 1'b1;
        alu_op = OP_DIVU;
        a      = 32'd50;
        b      = 32'd5;
        tick();
        start  = 1'b0;
        probe(c0 + 8, 1'b1, last_exp);
        probe(c0 + 11, 1'b0, last_exp);
        repeat (4) tick();                         // cycle c0+10
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (40) tick();
        run(OP_DIVU, 32'd9, 32'd2, 32'd4, 33, 32);

        // Reset in the middle of CALC clears everything.
        launch_raw(OP_DIVU, 32'd77, 32'd5);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        probe(cyc, 1'b0, 32'h0);
        repeat (40) tick();
        run(OP_DIVU, 32'd77, 32'd5, 32'd15, 33, 32);

        repeat (3) tick();
        finish_req = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d required=finish before timeout", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
